// File: rtl/circle_engine.sv
// Midpoint-circle rasteriser: outline with per-octant mask or filled disc,
// one candidate pixel per cycle on the VGA plotting port.
module circle_engine #(
  parameter int unsigned X_W      = 8,
  parameter int unsigned Y_W      = 7,
  parameter int unsigned R_W      = 8,
  parameter int unsigned COLOUR_W = 3,
  parameter int unsigned SCREEN_W = 160,
  parameter int unsigned SCREEN_H = 120
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [COLOUR_W-1:0] colour,
  input  logic [X_W-1:0]      centre_x,
  input  logic [Y_W-1:0]      centre_y,
  input  logic [R_W-1:0]      radius,
  input  logic [7:0]          octant_mask,
  input  logic                fill,
  output logic                done,
  output logic [X_W-1:0]      vga_x,
  output logic [Y_W-1:0]      vga_y,
  output logic [COLOUR_W-1:0] vga_colour,
  output logic                vga_plot
);

  localparam int unsigned RW   = R_W + 3;
  localparam int unsigned XY_W = (X_W > Y_W) ? X_W : Y_W;
  localparam int unsigned CW   = ((XY_W > R_W) ? XY_W : R_W) + 2;
  localparam logic signed [RW-1:0] ONE = RW'(1);

  typedef enum logic [2:0] {IDLE, PLOT, SPAN, UPDATE, DONE} state_t;

  state_t               state, state_n;
  logic [COLOUR_W-1:0]  colour_q, colour_n;
  logic [X_W-1:0]       cx_q, cx_n;
  logic [Y_W-1:0]       cy_q, cy_n;
  logic [7:0]           mask_q, mask_n;
  logic                 fill_q, fill_n;
  logic signed [RW-1:0] ox_q, ox_n, oy_q, oy_n, crit_q, crit_n, sx_q, sx_n;
  logic [2:0]           oct_q, oct_n;
  logic [1:0]           span_q, span_n;

  logic signed [RW-1:0] dx, dy, half, half_next, oy_inc, ox_new;
  logic signed [CW-1:0] px, py;
  logic                 active, on_screen;

  // Offset of the current candidate pixel relative to the centre
  always_comb begin
    dx = '0;
    dy = '0;
    if (state == SPAN) begin
      dx = sx_q;
      unique case (span_q)
        2'd0:    dy = oy_q;
        2'd1:    dy = -oy_q;
        2'd2:    dy = ox_q;
        default: dy = -ox_q;
      endcase
    end else begin
      unique case (oct_q)
        3'd0:    begin dx = ox_q;  dy = oy_q;  end
        3'd1:    begin dx = oy_q;  dy = ox_q;  end
        3'd2:    begin dx = -ox_q; dy = oy_q;  end
        3'd3:    begin dx = -oy_q; dy = ox_q;  end
        3'd4:    begin dx = -ox_q; dy = -oy_q; end
        3'd5:    begin dx = -oy_q; dy = -ox_q; end
        3'd6:    begin dx = ox_q;  dy = -oy_q; end
        default: begin dx = oy_q;  dy = -ox_q; end
      endcase
    end
  end

  // Spans 0/1 are ox wide, spans 2/3 are oy wide
  assign half      = span_q[1] ? oy_q : ox_q;
  assign half_next = (span_q == 2'd0) ? ox_q : oy_q;

  assign px = $signed(CW'(cx_q)) + CW'(dx);
  assign py = $signed(CW'(cy_q)) + CW'(dy);

  assign on_screen = !px[CW-1] && (px < $signed(CW'(SCREEN_W))) &&
                     !py[CW-1] && (py < $signed(CW'(SCREEN_H)));
  assign active    = (state == PLOT) || (state == SPAN);

  assign vga_plot   = active && on_screen && ((state == SPAN) || mask_q[oct_q]);
  assign vga_x      = active ? px[X_W-1:0] : '0;
  assign vga_y      = active ? py[Y_W-1:0] : '0;
  assign vga_colour = active ? colour_q : '0;
  assign done       = (state == DONE);

  // Next-state and datapath update
  always_comb begin
    state_n  = state;
    colour_n = colour_q;
    cx_n     = cx_q;
    cy_n     = cy_q;
    mask_n   = mask_q;
    fill_n   = fill_q;
    ox_n     = ox_q;
    oy_n     = oy_q;
    crit_n   = crit_q;
    sx_n     = sx_q;
    oct_n    = oct_q;
    span_n   = span_q;
    oy_inc   = oy_q + ONE;
    ox_new   = ox_q;

    unique case (state)
      IDLE: begin
        if (start) begin
          colour_n = colour;
          cx_n     = centre_x;
          cy_n     = centre_y;
          mask_n   = octant_mask;
          fill_n   = fill;
          ox_n     = $signed(RW'(radius));
          oy_n     = '0;
          crit_n   = ONE - $signed(RW'(radius));
          sx_n     = -$signed(RW'(radius));
          oct_n    = '0;
          span_n   = '0;
          state_n  = fill ? SPAN : PLOT;
        end
      end
      PLOT: begin
        oct_n = oct_q + 3'd1;
        if (oct_q == 3'd7) state_n = UPDATE;
      end
      SPAN: begin
        if (sx_q == half) begin
          if (span_q == 2'd3) begin
            state_n = UPDATE;
          end else begin
            span_n = span_q + 2'd1;
            sx_n   = -half_next;
          end
        end else begin
          sx_n = sx_q + ONE;
        end
      end
      UPDATE: begin
        if (crit_q[RW-1] || (crit_q == '0)) begin
          crit_n = crit_q + (oy_inc <<< 1) + ONE;
        end else begin
          ox_new = ox_q - ONE;
          crit_n = crit_q + ((oy_inc - ox_new) <<< 1) + ONE;
        end
        oy_n   = oy_inc;
        ox_n   = ox_new;
        sx_n   = -ox_new;
        oct_n  = '0;
        span_n = '0;
        if (oy_inc <= ox_new) state_n = fill_q ? SPAN : PLOT;
        else                  state_n = DONE;
      end
      DONE: begin
        if (!start) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      colour_q <= '0;
      cx_q     <= '0;
      cy_q     <= '0;
      mask_q   <= '0;
      fill_q   <= 1'b0;
      ox_q     <= '0;
      oy_q     <= '0;
      crit_q   <= '0;
      sx_q     <= '0;
      oct_q    <= '0;
      span_q   <= '0;
    end else begin
      state    <= state_n;
      colour_q <= colour_n;
      cx_q     <= cx_n;
      cy_q     <= cy_n;
      mask_q   <= mask_n;
      fill_q   <= fill_n;
      ox_q     <= ox_n;
      oy_q     <= oy_n;
      crit_q   <= crit_n;
      sx_q     <= sx_n;
      oct_q    <= oct_n;
      span_q   <= span_n;
    end
  end

endmodule

// File: tb/tb_circle_engine.sv
// Bench for circle_engine: per-cycle expected pixel stream built from the
// midpoint-circle rules with integer arithmetic, compared every cycle.
module tb_circle_engine;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [2:0] colour;
  logic [7:0] centre_x;
  logic [6:0] centre_y;
  logic [7:0] radius;
  logic [7:0] octant_mask;
  logic       fill;
  logic       done;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;

  circle_engine dut (
    .clk(clk), .rst_n(rst_n), .start(start), .colour(colour),
    .centre_x(centre_x), .centre_y(centre_y), .radius(radius),
    .octant_mask(octant_mask), .fill(fill), .done(done),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       plot;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
    logic       done;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc, plots, done_cyc, model_len, model_plots;
  bit   seen[3][3];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic push_pix(input int px, input int py, input bit en, input logic [2:0] col);
    exp_t e;
    bit on;
    on = (px >= 0) && (px < 160) && (py >= 0) && (py < 120);
    e.plot = en && on;
    e.x    = 8'(px);
    e.y    = 7'(py);
    e.c    = col;
    e.done = 1'b0;
    exp_q.push_back(e);
    model_len++;
    if (e.plot) model_plots++;
  endtask

  // Expected output of every cycle of one draw, starting with the first pixel
  task automatic build(input int cx, input int cy, input int r, input logic [7:0] mask,
                       input bit f, input logic [2:0] col, input bit hold);
    int x, y, d;
    int dxl[8], dyl[8], syl[4], hw[4];
    exp_t e;
    model_len = 0;
    model_plots = 0;
    x = r; y = 0; d = 1 - r;
    do begin
      if (!f) begin
        dxl = '{x, y, -x, -y, -x, -y, x, y};
        dyl = '{y, x, y, x, -y, -x, -y, -x};
        for (int k = 0; k < 8; k++) push_pix(cx + dxl[k], cy + dyl[k], mask[k], col);
      end else begin
        syl = '{y, -y, x, -x};
        hw  = '{x, x, y, y};
        for (int s = 0; s < 4; s++)
          for (int px = -hw[s]; px <= hw[s]; px++) push_pix(cx + px, cy + syl[s], 1'b1, col);
      end
      exp_q.push_back('0);
      model_len++;
      y++;
      if (d <= 0) d += 2 * y + 1;
      else begin x--; d += 2 * (y - x) + 1; end
    end while (y <= x);
    e = '0;
    e.done = 1'b1;
    exp_q.push_back(e);
    model_len++;
    if (!hold) exp_q.push_back('0);
  endtask

  // Compare process: one expected entry per cycle while a draw is in flight
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      cyc++;
      checks++;
      if ({vga_plot, vga_x, vga_y, vga_colour, done} !== e) begin
        failures++;
        $display("FAIL stream cyc=%0d actual plot=%0b x=%0d y=%0d c=%0d done=%0b required plot=%0b x=%0d y=%0d c=%0d done=%0b",
                 cyc, vga_plot, vga_x, vga_y, vga_colour, done, e.plot, e.x, e.y, e.c, e.done);
      end
      if (vga_plot) begin
        plots++;
        if (vga_x >= 8'd9 && vga_x <= 8'd11 && vga_y >= 7'd9 && vga_y <= 7'd11)
          seen[vga_x - 8'd9][vga_y - 7'd9] = 1'b1;
      end
      if (done && done_cyc == 0) done_cyc = cyc;
    end
  end

  task automatic draw(input int cx, input int cy, input int r, input logic [7:0] mask,
                      input bit f, input logic [2:0] col, input bit hold);
    int budget;
    @(negedge clk);
    cyc = 0; plots = 0; done_cyc = 0;
    for (int i = 0; i < 3; i++) for (int j = 0; j < 3; j++) seen[i][j] = 1'b0;
    build(cx, cy, r, mask, f, col, hold);
    centre_x = 8'(cx); centre_y = 7'(cy); radius = 8'(r);
    octant_mask = mask; fill = f; colour = col; start = 1'b1;
    @(negedge clk);
    if (!hold) start = 1'b0;
    centre_x = 8'($urandom); centre_y = 7'($urandom); radius = 8'($urandom);
    octant_mask = 8'($urandom); fill = 1'($urandom); colour = 3'($urandom);
    budget = exp_q.size() + 10;
    while (exp_q.size() > 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (exp_q.size() > 0) begin
      chk("draw_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  int stray;

  initial begin
    rst_n = 1'b0; start = 1'b0; colour = '0; centre_x = '0; centre_y = '0;
    radius = '0; octant_mask = '0; fill = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {done, vga_plot, vga_x, vga_y, vga_colour}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    draw(80, 60, 0, 8'hFF, 1'b0, 3'd5, 1'b0);
    chk("r0_model_len", model_len, 10);
    chk("r0_done_cycle", done_cyc, 10);
    chk("r0_plots", plots, 8);

    draw(80, 60, 1, 8'hFF, 1'b0, 3'd2, 1'b0);
    chk("r1_model_len", model_len, 19);
    chk("r1_done_cycle", done_cyc, 19);
    chk("r1_plots", plots, 16);

    draw(80, 60, 5, 8'h01, 1'b0, 3'd7, 1'b0);
    chk("r5_mask1_plots", plots, 4);
    chk("r5_mask1_done_cycle", done_cyc, 37);
    draw(80, 60, 5, 8'hFF, 1'b0, 3'd7, 1'b0);
    chk("r5_maskff_done_cycle", done_cyc, 37);
    chk("r5_maskff_plots", plots, 32);

    draw(0, 0, 10, 8'hFF, 1'b0, 3'd1, 1'b0);
    chk("clip_done_cycle", done_cyc, 73);

    draw(10, 10, 1, 8'h00, 1'b1, 3'd4, 1'b0);
    chk("fill_model_plots", model_plots, 20);
    chk("fill_done_cycle", done_cyc, 23);
    chk("fill_plots", plots, 20);
    stray = 0;
    for (int i = 0; i < 3; i++) for (int j = 0; j < 3; j++) if (!seen[i][j]) stray++;
    chk("fill_coverage_missing", stray, 0);

    // start held through completion
    draw(50, 40, 2, 8'hA5, 1'b0, 3'd3, 1'b1);
    repeat (3) begin
      @(posedge clk); #1;
      chk("hold_done", {done, vga_plot}, 2);
    end
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #1;
    chk("release_done", {done, vga_plot}, 0);
    @(posedge clk); #1;
    chk("no_redraw", {done, vga_plot}, 0);

    for (int n = 0; n < 16; n++) begin
      bit f;
      f = ($urandom_range(0, 3) == 0);
      draw($urandom_range(0, 255), $urandom_range(0, 127),
           f ? $urandom_range(0, 12) : $urandom_range(0, 70),
           8'($urandom), f, 3'($urandom), 1'b0);
    end

    // reset mid-draw
    @(negedge clk);
    build(80, 60, 30, 8'hFF, 1'b0, 3'd6, 1'b0);
    centre_x = 8'd80; centre_y = 7'd60; radius = 8'd30;
    octant_mask = 8'hFF; fill = 1'b0; colour = 3'd6; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    exp_q.delete();
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("reset_abort", {done, vga_plot}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    stray = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (vga_plot || done) stray++;
    end
    chk("post_reset_quiet", stray, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
